// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for the async FIFO: binary/Gray write pointers, full, level, sticky overflow.
// Latency: we to pointer/flag update 1 wclk; wr_en_mem is combinational. Optional almost_full via WPTR_ALMOST_FULL_EN.
module wptr_ctrl #(
    parameter int PTR_WIDTH = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                 wclk,
    input  logic                 w_rstn,
    input  logic                 we,
    input  logic [PTR_WIDTH:0]   g_rptr_s,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 wr_en_mem,
    output logic                 full,
    output logic [PTR_WIDTH:0]   level,
    output logic                 overflow,
    output logic                 almost_full
);

    // Inverting the top two Gray bits of the read pointer gives the write pointer value at full.
    localparam logic [PTR_WIDTH:0] FULL_MASK = (PTR_WIDTH+1)'(3) << (PTR_WIDTH-1);

    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] b_rptr_s;
    logic [PTR_WIDTH:0] level_next;

    assign wr_en_mem   = we & ~full & w_rstn;
    assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_en_mem};
    assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
    assign level_next  = b_wptr_next - b_rptr_s;

    for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_gray2bin
        assign b_rptr_s[i] = ^g_rptr_s[PTR_WIDTH:i];
    end

    always_ff @(posedge wclk or negedge w_rstn) begin
        if (!w_rstn) begin
            b_wptr   <= '0;
            g_wptr   <= '0;
            full     <= 1'b0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            b_wptr <= b_wptr_next;
            g_wptr <= g_wptr_next;
            full   <= (g_wptr_next == (g_rptr_s ^ FULL_MASK));
            level  <= level_next;
            if (we && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PTR_WIDTH:0] DEPTH  = (PTR_WIDTH+1)'(1) << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] AF_THR = (PTR_WIDTH+1)'(AF_MARGIN);

    logic [PTR_WIDTH:0] free_next;
    assign free_next = DEPTH - level_next;

    always_ff @(posedge wclk or negedge w_rstn) begin
        if (!w_rstn)
            almost_full <= 1'b0;
        else
            almost_full <= (free_next <= AF_THR);
    end
`else
    // Feature disabled: constant 0, the margin has no effect in this build.
    assign almost_full = 1'b0 & (AF_MARGIN > 0);
`endif

endmodule

// File: tb/tb_wptr_ctrl.sv
// Scoreboard bench for wptr_ctrl: driver pushes model predictions, monitor pops and compares each cycle.
module tb_wptr_ctrl;

    localparam int PW    = 4;
    localparam int DEPTH = 1 << PW;
    localparam int MOD   = 2 * DEPTH;
    localparam int AFM   = 2;

    logic          wclk = 1'b0;
    logic          w_rstn = 1'b0;
    logic          we = 1'b1;
    logic [PW:0]   g_rptr_s = '0;
    logic          ovf_clr = 1'b0;
    logic [PW:0]   b_wptr;
    logic [PW:0]   g_wptr;
    logic          wr_en_mem;
    logic          full;
    logic [PW:0]   level;
    logic          overflow;
    logic          almost_full;

    wptr_ctrl #(.PTR_WIDTH(PW), .AF_MARGIN(AFM)) dut (
        .wclk        (wclk),
        .w_rstn      (w_rstn),
        .we          (we),
        .g_rptr_s    (g_rptr_s),
        .ovf_clr     (ovf_clr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .wr_en_mem   (wr_en_mem),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .almost_full (almost_full)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic        rstn;
        logic        wr;
        logic [PW:0] b;
        logic [PW:0] g;
        logic [PW:0] lvl;
        logic        full;
        logic        ovf;
        logic        af;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: write count and read position modulo 2*DEPTH.
    int m_wp   = 0;
    int m_full = 0;
    int m_ovf  = 0;
    int rp     = 0;

    function automatic logic [PW:0] to_gray(input int v);
        logic [PW:0] b;
        b = (PW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit rstn_i, input bit we_i, input bit clr_i, input int rp_i);
        exp_t e;
        int   occ;
        bit   acc;
        @(negedge wclk);
        w_rstn   = rstn_i;
        we       = we_i;
        ovf_clr  = clr_i;
        g_rptr_s = to_gray(rp_i);
        e = '0;
        e.rstn = rstn_i;
        if (!rstn_i) begin
            m_wp = 0; m_full = 0; m_ovf = 0;
        end else begin
            acc = we_i && (m_full == 0);
            if (we_i && m_full != 0) m_ovf = 1;
            else if (clr_i)          m_ovf = 0;
            if (acc) m_wp = (m_wp + 1) % MOD;
            occ    = (m_wp - rp_i + MOD) % MOD;
            m_full = (occ == DEPTH) ? 1 : 0;
            e.wr   = acc;
            e.b    = (PW+1)'(m_wp);
            e.g    = to_gray(m_wp);
            e.lvl  = (PW+1)'(occ);
            e.full = (m_full != 0);
            e.ovf  = (m_ovf != 0);
`ifdef WPTR_ALMOST_FULL_EN
            e.af   = (DEPTH - occ) <= AFM;
`else
            e.af   = 1'b0;
`endif
        end
        sbq.push_back(e);
    endtask

    // Monitor: strobe sampled mid-low-phase, registered outputs 1 time unit after the edge.
    initial begin
        exp_t        e;
        logic        s_wr;
        logic [PW:0] prev_g = '0;
        bit          prev_ok = 0;
        forever begin
            @(negedge wclk);
            #3;
            s_wr = wr_en_mem;
            @(posedge wclk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("wr_en_mem",   int'(s_wr),        int'(e.wr));
                check("b_wptr",      int'(b_wptr),      int'(e.b));
                check("g_wptr",      int'(g_wptr),      int'(e.g));
                check("level",       int'(level),       int'(e.lvl));
                check("full",        int'(full),        int'(e.full));
                check("overflow",    int'(overflow),    int'(e.ovf));
                check("almost_full", int'(almost_full), int'(e.af));
                if (prev_ok && e.rstn)
                    check("g_wptr_onebit", (($countones(g_wptr ^ prev_g) <= 1) ? 1 : 0), 1);
                prev_g  = g_wptr;
                prev_ok = e.rstn;
            end
        end
    end

    initial begin
        int drain;
        // Reset held with we high
        repeat (3) cycle(0, 1, 0, 0);
        // Fill to full, then one overflowing write
        rp = 0;
        repeat (16) cycle(1, 1, 0, rp);
        cycle(1, 1, 0, rp);
        cycle(1, 0, 0, rp);
        // Drain visibility: one read appears, then refill
        rp = 1;
        cycle(1, 0, 0, rp);
        cycle(1, 1, 0, rp);
        cycle(1, 0, 0, rp);
        // Overflow clear alone, then clear racing an overflowing write
        cycle(1, 0, 1, rp);
        cycle(1, 1, 1, rp);
        cycle(1, 0, 0, rp);
        // Wrap with read pointer trailing so level settles at 3
        for (int i = 0; i < 40; i++) begin
            rp = (m_wp + 1 - 3 + MOD) % MOD;
            cycle(1, 1, 0, rp);
        end
        // Mid-burst reset
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        rp = 0;
        // Random traffic with realistic one-step read pointer movement
        for (int i = 0; i < 600; i++) begin
            bit rs;
            rs = ($urandom_range(0, 99) != 0);
            if (!rs) begin
                rp = 0;
            end else if ((m_wp - rp + MOD) % MOD > 0 && $urandom_range(0, 99) < 40) begin
                rp = (rp + 1) % MOD;
            end
            cycle(rs, ($urandom_range(0, 99) < 70), ($urandom_range(0, 9) == 0), rp);
        end
        drain = 0;
        while (sbq.size() > 0 && drain < 10) begin
            @(posedge wclk);
            drain++;
        end
        @(negedge wclk);
        if (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d records left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wptr_ctrl.md
Name: wptr_ctrl

Overview:
Write-domain pointer controller of the parameterized async FIFO; mirror of the read-side pointer controller. Accepts write requests, advances binary and Gray write pointers, and generates the memory write strobe. Computes full, fill level and a sticky overflow flag against the read pointer synchronized into wclk. g_wptr feeds the 2-flop synchronizer into the read domain; b_wptr[PTR_WIDTH-1:0] addresses the dual-port memory.

Parameters:
PTR_WIDTH, 4, address width; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits (MSB = wrap bit).
AF_MARGIN, 2, almost_full asserts when free slots <= AF_MARGIN (used only with WPTR_ALMOST_FULL_EN); legal range 1..2**PTR_WIDTH-1.

Ports:
wclk  input  1  write clock; all state on rising edge.
w_rstn  input  1  asynchronous active-low reset.
we  input  1  write request from producer.
g_rptr_s  input  PTR_WIDTH+1  Gray read pointer, already synchronized into wclk.
ovf_clr  input  1  clears sticky overflow.
b_wptr  output  PTR_WIDTH+1  registered binary write pointer.
g_wptr  output  PTR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
wr_en_mem  output  1  combinational write strobe = we & ~full.
full  output  1  registered full flag.
level  output  PTR_WIDTH+1  registered occupancy as seen from write domain, 0..2**PTR_WIDTH.
overflow  output  1  sticky: a write was attempted while full.
almost_full  output  1  registered; see Optional Feature.

Behaviour:
- Reset (async assert, sync-released by system): b_wptr=0, g_wptr=0, full=0, level=0, overflow=0, almost_full=0. Reset mid-burst discards pointer state immediately; no write strobe while w_rstn low.
- Accept: wr_en_mem = we & ~full. b_wptr_next = b_wptr + wr_en_mem (mod 2**(PTR_WIDTH+1), natural wrap); g_wptr_next = (b_wptr_next>>1) ^ b_wptr_next. Both pointers registered together; g_wptr only ever changes by one bit per cycle.
- Read pointer: g_rptr_s converted to binary b_rptr_s via internal Gray-to-binary logic (XOR prefix from MSB).
- Full: full <= (g_wptr_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]}). For PTR_WIDTH==1 compare to ~g_rptr_s[1:0]. Full asserts in the same edge that accepts the last free slot (no extra latency). Full is pessimistic: deasserts only after the read pointer crosses the synchronizer (2-3 wclk after the read).
- Level: level <= b_wptr_next - b_rptr_s, computed in PTR_WIDTH+1 bits modulo 2**(PTR_WIDTH+1); wrap-bit difference handles pointer wrap without special cases. level==2**PTR_WIDTH iff full.
- Overflow: set when we & full; cleared by ovf_clr; set wins when both in same cycle. Overflowed writes do not move pointers or strobe memory.
- Simultaneous write and read-pointer update in one cycle: both reflected in the next full/level value.
- Single state-free datapath plus registered flags; no FSM beyond pointer counter. Latency: we to g_wptr change = 1 wclk.

Optional Feature:
Macro WPTR_ALMOST_FULL_EN. Defined: almost_full <= ((2**PTR_WIDTH) - level_next) <= AF_MARGIN, registered alongside full, reset 0; asserts with full. Undefined: almost_full tied to 0, no comparator logic generated, AF_MARGIN ignored.

Test Plan:
Reset: hold w_rstn low with we=1 -> all outputs 0, wr_en_mem=0; release -> first write gives b_wptr=1, g_wptr=1.
Fill (PTR_WIDTH=4, g_rptr_s=0): 16 consecutive writes -> full=1 on the edge of the 16th, level=16, b_wptr=5'h10, g_wptr=5'h18; 17th we -> wr_en_mem=0, pointers unchanged, overflow=1.
Drain visibility: from full, step g_rptr_s 0->1 -> next edge full=0, level=15; one write -> full=1 again, b_wptr=5'h11.
Wrap: drive 40 writes with g_rptr_s tracking b_wptr-3 (in Gray) -> level stays 3, full never asserts, b_wptr wraps 31->0, g_wptr changes one bit per accept.
Overflow clear: overflow=1, assert ovf_clr with we=0 -> overflow=0; ovf_clr and overflowing we same cycle -> overflow stays 1.
WPTR_ALMOST_FULL_EN, AF_MARGIN=2, g_rptr_s=0: after 14th write almost_full=1, full=0; undefined build -> almost_full=0 throughout.
